// File: rtl/subtrator_serial.sv
`default_nettype none
// ============================================================================
// Module   : subtrator_serial
// Purpose  : Bit-serial subtractor recovering A = S - B (LSB first) with
//            valid/ready handshakes and borrow-out / overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module subtrator_serial #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   S,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic             underflow,
  output logic             overflow
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 2);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH:0]     r_s_sh;
  logic [WIDTH:0]     r_b_sh;
  logic [WIDTH:0]     r_diff;
  logic               r_brw;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_s_bit;
  logic               w_b_bit;
  logic               w_d_bit;
  logic               w_brw_nxt;
  logic [WIDTH:0]     w_diff_nxt;

  // One full-subtractor cell; the difference bit enters at the top so that
  // after WIDTH+1 shifts bit 0 of the result sits at position 0.
  assign w_s_bit    = r_s_sh[0];
  assign w_b_bit    = r_b_sh[0];
  assign w_d_bit    = w_s_bit ^ w_b_bit ^ r_brw;
  assign w_brw_nxt  = (~w_s_bit & w_b_bit) | (~(w_s_bit ^ w_b_bit) & r_brw);
  assign w_diff_nxt = {w_d_bit, r_diff[WIDTH:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_s_sh    <= '0;
      r_b_sh    <= '0;
      r_diff    <= '0;
      r_brw     <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      A         <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            r_s_sh   <= S;
            r_b_sh   <= {1'b0, B};
            r_diff   <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= ST_CALC;
          end
        end

        ST_CALC: begin
          r_s_sh <= {1'b0, r_s_sh[WIDTH:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH:1]};
          r_brw  <= w_brw_nxt;
          r_diff <= w_diff_nxt;
          r_cnt  <= r_cnt + c_ONE;
          // Publish straight from the last cell so out_valid is not delayed a cycle.
          if (r_cnt == c_LAST) begin
            out_valid <= 1'b1;
            A         <= w_diff_nxt[WIDTH-1:0];
            underflow <= w_brw_nxt;
            overflow  <= w_diff_nxt[WIDTH] & ~w_brw_nxt;
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_subtrator_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtrator_serial
// Purpose  : Self-checking bench for subtrator_serial (WIDTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtrator_serial;

  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   S;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] A;
  logic         underflow;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W:0] q_ops[$];

  subtrator_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .underflow (underflow),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction.
  function automatic logic [W+1:0] model(input logic [W:0] s, input logic [W-1:0] b);
    int d;
    logic [31:0] dv;
    logic uf, of;
    d  = int'(s) - int'(b);
    dv = d;
    uf = (d < 0);
    of = (d >= (1 << W));
    return {uf, of, dv[W-1:0]};
  endfunction

  // Track accepted operand pairs and retired results.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ops.delete();
    end else begin
      if (out_valid && out_ready && q_ops.size() > 0) void'(q_ops.pop_front());
      if (in_valid && in_ready) q_ops.push_back({S, B});
    end
  end

  // Compare the DUT against the model on every cycle its output is valid.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_ready_exclusive", {31'd0, out_valid & in_ready}, 32'd0);
      if (out_valid) begin
        if (q_ops.size() == 0) begin
          check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = model(q_ops[0][2*W:W], q_ops[0][W-1:0]);
          check("model_A",  {{(32-W){1'b0}}, A}, {{(32-W){1'b0}}, e[W-1:0]});
          check("model_uf", {31'd0, underflow},  {31'd0, e[W+1]});
          check("model_of", {31'd0, overflow},   {31'd0, e[W]});
        end
      end
    end
  end

  // Present an operand pair and return right after the accepting edge.
  task automatic drive_accept(input logic [W:0] s, input logic [W-1:0] b);
    int waited;
    @(negedge clk);
    S = s; B = b; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count accept-to-out_valid edges; 0 means timed out.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_out(input int stall);
    logic [W-1:0] a0;
    a0 = A;
    out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_A_stable", {{(32-W){1'b0}}, A}, {{(32-W){1'b0}}, a0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  task automatic directed(input string name, input logic [W:0] s, input logic [W-1:0] b,
                          input logic [W-1:0] ea, input logic euf, input logic eof);
    int lat;
    drive_accept(s, b);
    wait_out(lat);
    check({name, "_latency"}, lat, W + 1);
    check({name, "_A"},  {{(32-W){1'b0}}, A}, {{(32-W){1'b0}}, ea});
    check({name, "_uf"}, {31'd0, underflow}, {31'd0, euf});
    check({name, "_of"}, {31'd0, overflow},  {31'd0, eof});
    release_out(0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] a_hold;
    logic uf_hold, of_hold;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; S = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_A",         {{(32-W){1'b0}}, A}, 32'd0);
    check("rst_flags",     {30'd0, underflow, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    directed("t1",   3'b101, 2'b10, 2'b11, 1'b0, 1'b0);
    directed("t2",   3'b001, 2'b11, 2'b10, 1'b1, 1'b0);
    directed("t3a",  3'b111, 2'b00, 2'b11, 1'b0, 1'b1);
    directed("t3b",  3'b011, 2'b11, 2'b00, 1'b0, 1'b0);
    directed("zmax", 3'b000, 2'b11, 2'b01, 1'b1, 1'b0);

    // Backpressure with a second operand pair held on the input.
    drive_accept(3'b110, 2'b01);
    wait_out(lat);
    check("bp_latency", lat, W + 1);
    a_hold = A; uf_hold = underflow; of_hold = overflow;
    check("bp_A",  {{(32-W){1'b0}}, a_hold}, 32'd1);
    check("bp_of", {31'd0, of_hold}, 32'd1);
    S = 3'b010; B = 2'b01; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_A",        {{(32-W){1'b0}}, A}, {{(32-W){1'b0}}, a_hold});
      check("bp_hold_flags",    {30'd0, underflow, overflow}, {30'd0, uf_hold, of_hold});
      check("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_valid", {31'd0, out_valid}, 32'd0);
    check("bp_rel_ready", {31'd0, in_ready},  32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    check("bp2_latency", lat, W + 1);
    check("bp2_A", {{(32-W){1'b0}}, A}, 32'd1);
    check("bp2_flags", {30'd0, underflow, overflow}, 32'd0);
    release_out(0);

    // Reset in the second calculation cycle aborts the operation.
    drive_accept(3'b101, 2'b10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_A",         {{(32-W){1'b0}}, A}, 32'd0);
    check("abort_flags",     {30'd0, underflow, overflow}, 32'd0);
    check("abort_in_ready",  {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_rel_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_result", {31'd0, out_valid}, 32'd0);
    end

    // All operand pairs back-to-back with random consumer stalls.
    for (int s = 0; s < (1 << (W + 1)); s++) begin
      for (int b = 0; b < (1 << W); b++) begin
        drive_accept(s[W:0], b[W-1:0]);
        wait_out(lat);
        check("ex_latency", lat, W + 1);
        release_out(int'($urandom_range(0, 3)));
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
